// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that shares the VGA adapter plot port among three rectangle drawers.
// The granted rectangle is rasterised one pixel per clock, row-major, with off-screen clipping.
module vga_plot_arbiter #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [23:0] rect_x,
  input  logic [20:0] rect_y,
  input  logic [23:0] rect_w,
  input  logic [20:0] rect_h,
  input  logic [8:0]  rect_color,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        busy,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  color_out,
  output logic        writeEn
);

  localparam logic [8:0] XLimit = 9'(SCREEN_W);
  localparam logic [7:0] YLimit = 8'(SCREEN_H);

  typedef enum logic {StIdle, StDraw} state_e;

  state_e      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic [7:0]  x_out_q, x_out_d;
  logic [6:0]  y_out_q, y_out_d;
  logic [2:0]  color_out_q, color_out_d;
  logic        we_q, we_d;
  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic [7:0]  w_q, w_d;
  logic [6:0]  h_q, h_d;
  logic [2:0]  c_q, c_d;
  logic [7:0]  col_q, col_d;
  logic [6:0]  row_q, row_d;

  logic [2:0]  eligible;
  logic [1:0]  p0, p1, p2;
  logic        win;
  logic [1:0]  win_idx;
  logic [7:0]  sel_x, sel_w;
  logic [6:0]  sel_y, sel_h;
  logic [2:0]  sel_c;
  logic [8:0]  x_sum;
  logic [7:0]  y_sum;
  logic        on_screen;
  logic        row_end;
  logic        last_pixel;

  // A requester whose done is high this cycle is masked so a held req is not re-granted.
  assign eligible = req & ~done_q;

  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (last_q)
      2'd0: begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1: begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    win     = 1'b1;
    win_idx = p0;
    if (eligible[p0]) begin
      win_idx = p0;
    end else if (eligible[p1]) begin
      win_idx = p1;
    end else if (eligible[p2]) begin
      win_idx = p2;
    end else begin
      win = 1'b0;
    end
  end

  always_comb begin
    sel_x = rect_x[7:0];
    sel_y = rect_y[6:0];
    sel_w = rect_w[7:0];
    sel_h = rect_h[6:0];
    sel_c = rect_color[2:0];
    case (win_idx)
      2'd1: begin
        sel_x = rect_x[15:8];
        sel_y = rect_y[13:7];
        sel_w = rect_w[15:8];
        sel_h = rect_h[13:7];
        sel_c = rect_color[5:3];
      end
      2'd2: begin
        sel_x = rect_x[23:16];
        sel_y = rect_y[20:14];
        sel_w = rect_w[23:16];
        sel_h = rect_h[20:14];
        sel_c = rect_color[8:6];
      end
      default: ;
    endcase
  end

  // Sums are one bit wider than the outputs so wrap-around past the edge is still clipped.
  assign x_sum      = {1'b0, x0_q} + {1'b0, col_q};
  assign y_sum      = {1'b0, y0_q} + {1'b0, row_q};
  assign on_screen  = (x_sum < XLimit) && (y_sum < YLimit);
  assign row_end    = (col_q == w_q - 8'd1);
  assign last_pixel = row_end && (row_q == h_q - 7'd1);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    busy_d      = busy_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    color_out_d = color_out_q;
    we_d        = we_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    c_d         = c_q;
    col_d       = col_q;
    row_d       = row_q;
    unique case (state_q)
      StIdle: begin
        we_d   = 1'b0;
        done_d = 3'b000;
        gnt_d  = 3'b000;
        busy_d = 1'b0;
        if (win) begin
          gnt_d  = 3'b001 << win_idx;
          last_d = win_idx;
          x0_d   = sel_x;
          y0_d   = sel_y;
          w_d    = sel_w;
          h_d    = sel_h;
          c_d    = sel_c;
          if (sel_w == 8'd0 || sel_h == 7'd0) begin
            done_d = 3'b001 << win_idx;
          end else begin
            state_d = StDraw;
            col_d   = 8'd0;
            row_d   = 7'd0;
            busy_d  = 1'b1;
          end
        end
      end
      StDraw: begin
        done_d      = 3'b000;
        x_out_d     = x_sum[7:0];
        y_out_d     = y_sum[6:0];
        color_out_d = c_q;
        we_d        = on_screen;
        if (last_pixel) begin
          done_d  = gnt_q;
          busy_d  = 1'b0;
          gnt_d   = 3'b000;
          state_d = StIdle;
        end else if (row_end) begin
          col_d = 8'd0;
          row_d = row_q + 7'd1;
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      last_q      <= 2'd2;
      gnt_q       <= 3'b000;
      done_q      <= 3'b000;
      busy_q      <= 1'b0;
      x_out_q     <= 8'd0;
      y_out_q     <= 7'd0;
      color_out_q <= 3'd0;
      we_q        <= 1'b0;
      x0_q        <= 8'd0;
      y0_q        <= 7'd0;
      w_q         <= 8'd0;
      h_q         <= 7'd0;
      c_q         <= 3'd0;
      col_q       <= 8'd0;
      row_q       <= 7'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      color_out_q <= color_out_d;
      we_q        <= we_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      c_q         <= c_d;
      col_q       <= col_d;
      row_q       <= row_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign color_out = color_out_q;
  assign writeEn   = we_q;

endmodule
